// File: rtl/spy_bus_ctl.sv
// Spy-bus access sequencer: runs a single host read or write through the
// SETUP, STROBE and ACK phases and drives the spy mux and load strobes.
module spy_bus_ctl #(
    parameter int STROBE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [15:0] wdata,
    input  logic [15:0] spy_in,
    output logic        busy,
    output logic        ack,
    output logic [15:0] rdata,
    output logic [31:0] spy_sel,
    output logic        dbread,
    output logic        dbwrite,
    output logic [5:0]  ld,
    output logic [15:0] spy_wdata
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, ACK} state_t;

    state_t      state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic        we_q;
    logic [4:0]  addr_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;
    logic        rd_valid;

    function automatic logic [5:0] ld_decode(input logic [4:0] a);
        case (a)
            5'h00:   ld_decode = 6'b000001;
            5'h01:   ld_decode = 6'b000010;
            5'h02:   ld_decode = 6'b000100;
            5'h03:   ld_decode = 6'b001000;
            5'h08:   ld_decode = 6'b010000;
            5'h09:   ld_decode = 6'b100000;
            default: ld_decode = 6'b000000;
        endcase
    endfunction

    // Only addresses 0x00..0x17 have a source on the spy mux.
    assign rd_valid = (addr_q[4:3] != 2'b11);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            we_q    <= 1'b0;
            addr_q  <= 5'd0;
            wdata_q <= 16'd0;
            rdata_q <= 16'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && req) begin
                we_q   <= we;
                addr_q <= addr;
                if (we)
                    wdata_q <= wdata;
            end
            // Capture on the last strobe edge, after spy_in has settled.
            if (state == STROBE && cnt == 3'd1 && !we_q)
                rdata_q <= rd_valid ? spy_in : 16'hFFFF;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy      = 1'b1;
        ack       = 1'b0;
        spy_sel   = 32'd0;
        dbread    = 1'b0;
        dbwrite   = 1'b0;
        ld        = 6'd0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (req)
                    state_nxt = SETUP;
            end
            SETUP: begin
                if (!we_q && rd_valid)
                    spy_sel = 32'd1 << addr_q;
                state_nxt = STROBE;
                cnt_nxt   = 3'(STROBE_CYCLES);
            end
            STROBE: begin
                if (!we_q && rd_valid)
                    spy_sel = 32'd1 << addr_q;
                dbread  = !we_q && rd_valid;
                dbwrite = we_q;
                ld      = we_q ? ld_decode(addr_q) : 6'd0;
                if (cnt <= 3'd1) begin
                    state_nxt = ACK;
                    cnt_nxt   = 3'd0;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            ACK: begin
                ack       = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    assign rdata     = rdata_q;
    assign spy_wdata = wdata_q;

endmodule
